// File: rtl/smart_door_ctrl.sv
// smart_door_ctrl
//   Door-passage controller for a room people counter. Two IR beams straddle
//   the doorway (outer and inner). Both beams are synchronised and debounced.
//   The order in which the filtered beams break is tracked, and only a
//   complete passage produces a count pulse.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   sensor_out    raw outer beam, 1 = broken, asynchronous to clk
//   sensor_in     raw inner beam, 1 = broken, asynchronous to clk
//   people_count  current occupancy from the people counter
//   inc_pulse     one-cycle pulse, completed entry counted
//   dec_pulse     one-cycle pulse, completed exit counted
//   reject_pulse  one-cycle pulse, completed passage refused (full or empty)
//   door_lock     combinational, people_count >= MAX_PEOPLE
//   passage_busy  FSM is not idle
//   fault         FSM is in the fault state
module smart_door_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int MAX_PEOPLE      = 10,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_out,
  input  logic             sensor_in,
  input  logic [CNT_W-1:0] people_count,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             reject_pulse,
  output logic             door_lock,
  output logic             passage_busy,
  output logic             fault
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0]  DbLast    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TmoMax    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxPeople = CNT_W'(MAX_PEOPLE);

  typedef enum logic [2:0] {
    IDLE, E_OUT, E_BOTH, E_IN, X_IN, X_BOTH, X_OUT, FAULT
  } state_t;

  // Bit 1 is the outer beam, bit 0 the inner beam throughout.
  logic [1:0]      raw;
  logic [1:0]      meta_q;
  logic [1:0]      sync_q;
  logic [1:0]      filt_q;
  logic [DB_W-1:0] dbCnt_q [2];

  state_t          state_q, state_d, stateNext;
  logic [TMO_W-1:0] timer_q;
  logic            timeout;
  logic            entryDone, exitDone;
  logic            inc_q, dec_q, reject_q, busy_q, fault_q;

  assign raw = {sensor_out, sensor_in};

  // Two-flop synchroniser followed by a debouncer: the filtered value only
  // follows the synchronised value after DEBOUNCE_CYCLES consecutive cycles
  // of disagreement; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      filt_q <= '0;
      for (int s = 0; s < 2; s++) dbCnt_q[s] <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      for (int s = 0; s < 2; s++) begin
        if (sync_q[s] == filt_q[s]) begin
          dbCnt_q[s] <= '0;
        end else if (dbCnt_q[s] == DbLast) begin
          dbCnt_q[s] <= '0;
          filt_q[s]  <= sync_q[s];
        end else begin
          dbCnt_q[s] <= dbCnt_q[s] + 1'b1;
        end
      end
    end
  end

  // Passage sequencing on the filtered beams {fo,fi}. A timeout while a
  // passage state has been held too long wins over any normal transition,
  // including a completion, so a timed-out passage never counts.
  always_comb begin
    stateNext = state_q;
    entryDone = 1'b0;
    exitDone  = 1'b0;
    case (state_q)
      IDLE: begin
        case (filt_q)
          2'b10:   stateNext = E_OUT;
          2'b01:   stateNext = X_IN;
          2'b11:   stateNext = FAULT;
          default: stateNext = IDLE;
        endcase
      end
      E_OUT: begin
        case (filt_q)
          2'b11:   stateNext = E_BOTH;
          2'b00:   stateNext = IDLE;
          2'b01:   stateNext = FAULT;
          default: stateNext = E_OUT;
        endcase
      end
      E_BOTH: begin
        case (filt_q)
          2'b01:   stateNext = E_IN;
          2'b10:   stateNext = E_OUT;
          2'b00:   stateNext = FAULT;
          default: stateNext = E_BOTH;
        endcase
      end
      E_IN: begin
        case (filt_q)
          2'b00: begin
            stateNext = IDLE;
            entryDone = 1'b1;
          end
          2'b11:   stateNext = E_BOTH;
          2'b10:   stateNext = FAULT;
          default: stateNext = E_IN;
        endcase
      end
      X_IN: begin
        case (filt_q)
          2'b11:   stateNext = X_BOTH;
          2'b00:   stateNext = IDLE;
          2'b10:   stateNext = FAULT;
          default: stateNext = X_IN;
        endcase
      end
      X_BOTH: begin
        case (filt_q)
          2'b10:   stateNext = X_OUT;
          2'b01:   stateNext = X_IN;
          2'b00:   stateNext = FAULT;
          default: stateNext = X_BOTH;
        endcase
      end
      X_OUT: begin
        case (filt_q)
          2'b00: begin
            stateNext = IDLE;
            exitDone  = 1'b1;
          end
          2'b11:   stateNext = X_BOTH;
          2'b01:   stateNext = FAULT;
          default: stateNext = X_OUT;
        endcase
      end
      FAULT: begin
        if (filt_q == 2'b00) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    timeout = (timer_q == TmoMax) && (state_q != IDLE) && (state_q != FAULT);
    state_d = timeout ? FAULT : stateNext;
    if (timeout) begin
      entryDone = 1'b0;
      exitDone  = 1'b0;
    end
  end

  // State, dwell timer and registered outputs. Pulses are computed from the
  // transition being taken, so they appear together with the return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == IDLE || state_q == FAULT) begin
        timer_q <= '0;
      end else if (timer_q != TmoMax) begin
        timer_q <= timer_q + 1'b1;
      end
      inc_q    <= entryDone && (people_count < MaxPeople);
      dec_q    <= exitDone && (people_count != '0);
      reject_q <= (entryDone && (people_count >= MaxPeople)) ||
                  (exitDone && (people_count == '0));
      busy_q   <= (state_d != IDLE);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign inc_pulse    = inc_q;
  assign dec_pulse    = dec_q;
  assign reject_pulse = reject_q;
  assign passage_busy = busy_q;
  assign fault        = fault_q;
  assign door_lock    = (people_count >= MaxPeople);

endmodule

// File: tb/tb_smart_door_ctrl.sv
// tb_smart_door_ctrl
//   Directed bench for smart_door_ctrl. Stimulus pushes the pulse it expects
//   ({inc,dec,reject}) into a queue; a monitor on the falling edge pops and
//   compares every pulse the DUT presents, flagging unexpected pulses.
module tb_smart_door_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 64;
  localparam logic [2:0] EV_INC = 3'b100;
  localparam logic [2:0] EV_DEC = 3'b010;
  localparam logic [2:0] EV_REJ = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_out = 1'b0;
  logic       sensor_in = 1'b0;
  logic [4:0] people_count = 5'd0;
  logic       inc_pulse, dec_pulse, reject_pulse, door_lock, passage_busy, fault;

  logic [2:0] expQ [$];
  int         checks = 0;
  int         passes = 0;

  smart_door_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .MAX_PEOPLE     (10),
    .CNT_W          (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_out  (sensor_out),
    .sensor_in   (sensor_in),
    .people_count(people_count),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .reject_pulse(reject_pulse),
    .door_lock   (door_lock),
    .passage_busy(passage_busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Drive both raw beams just after a rising edge and hold for n edges.
  task automatic applyStimulus(input logic outB, input logic inB, input int n);
    sensor_out = outB;
    sensor_in  = inB;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic fullEntry();
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 10);
  endtask

  task automatic fullExit();
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b1, 1'b0, 10);
  endtask

  // Pulse monitor: every pulse must match the head of the expectation queue;
  // a two-cycle pulse shows up as an unexpected second pulse.
  always @(negedge clk) begin
    if (!reset && (inc_pulse || dec_pulse || reject_pulse)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", int'({inc_pulse, dec_pulse, reject_pulse}), 0);
      end else begin
        checkOutput("pulse_kind", int'({inc_pulse, dec_pulse, reject_pulse}),
                    int'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    people_count = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(passage_busy), 0);
    checkOutput("reset_fault", int'(fault), 0);
    checkOutput("reset_pulses", int'({inc_pulse, dec_pulse, reject_pulse}), 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 5);

    // 1. Normal entry
    fullEntry();
    expQ.push_back(EV_INC);
    applyStimulus(1'b0, 1'b0, 10);
    waitDrain("entry_inc", 20);
    checkOutput("entry_busy_after", int'(passage_busy), 0);
    checkOutput("entry_door_lock", int'(door_lock), 0);

    // 2. Normal exit, then an aborted entry
    fullExit();
    expQ.push_back(EV_DEC);
    applyStimulus(1'b0, 1'b0, 10);
    waitDrain("exit_dec", 20);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("abort_busy_during", int'(passage_busy), 1);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("abort_busy_after", int'(passage_busy), 0);

    // 3. Full room refuses entry, empty room refuses exit, 9 still admits
    people_count = 5'd10;
    #1;
    checkOutput("full_door_lock", int'(door_lock), 1);
    fullEntry();
    expQ.push_back(EV_REJ);
    applyStimulus(1'b0, 1'b0, 10);
    waitDrain("full_reject", 20);
    people_count = 5'd0;
    #1;
    checkOutput("empty_door_lock", int'(door_lock), 0);
    fullExit();
    expQ.push_back(EV_REJ);
    applyStimulus(1'b0, 1'b0, 10);
    waitDrain("empty_reject", 20);
    people_count = 5'd9;
    #1;
    checkOutput("nine_door_lock", int'(door_lock), 0);
    fullEntry();
    expQ.push_back(EV_INC);
    applyStimulus(1'b0, 1'b0, 10);
    waitDrain("nine_inc", 20);

    // 4. Short glitches on the outer beam never reach the FSM
    people_count = 5'd3;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 2);
      if (passage_busy) n++;
    end
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("glitch_busy_cycles", n, 0);
    checkOutput("glitch_fault", int'(fault), 0);

    // 5. Timeout in E_BOTH: 2 sync + debounce + 1 FSM edge + TMO dwell
    applyStimulus(1'b1, 1'b0, 10);
    sensor_in = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && !fault; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeout_latency", n, 2 + DEB + 1 + TMO);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("fault_held", int'(fault), 1);
    checkOutput("fault_busy", int'(passage_busy), 1);
    sensor_out = 1'b0;
    sensor_in  = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && fault; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("fault_clear_latency", n, 2 + DEB + 1);
    checkOutput("fault_clear_busy", int'(passage_busy), 0);
    applyStimulus(1'b0, 1'b0, 5);
    fullEntry();
    expQ.push_back(EV_INC);
    applyStimulus(1'b0, 1'b0, 10);
    waitDrain("post_fault_inc", 20);

    // 6. Reset mid-entry discards it; a still-broken inner beam reads as exit start
    fullEntry();
    checkOutput("e_in_busy", int'(passage_busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", int'(passage_busy), 0);
    checkOutput("async_reset_pulses", int'({inc_pulse, dec_pulse, reject_pulse, fault}), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 12);
    checkOutput("x_in_busy", int'(passage_busy), 1);
    checkOutput("x_in_fault", int'(fault), 0);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("x_in_abort_busy", int'(passage_busy), 0);

    waitDrain("final_queue", 10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/smart_door_ctrl.md
Name: smart_door_ctrl

Overview:
Door-passage controller that sequences the room's people counter. Two IR beam sensors straddle the doorway. The block synchronises and debounces both sensors and tracks the order in which the beams break, so that only a complete passage counts. It emits single-cycle increment/decrement pulses that drive the counter's switchA/switchB inputs, and it also produces the door lock, reject and fault indications.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a filtered sensor changes (>=1)
TIMEOUT_CYCLES, 64, maximum cycles allowed in any passage state before a fault (>=2)
MAX_PEOPLE, 10, occupancy at or above which entry is refused
CNT_W, 5, width of the people_count input

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sensor_out  input  1  raw outer beam, 1 = broken, asynchronous to clk
sensor_in  input  1  raw inner beam, 1 = broken, asynchronous to clk
people_count  input  CNT_W  current occupancy from the people counter
inc_pulse  output  1  one-cycle pulse to the counter's increment input
dec_pulse  output  1  one-cycle pulse to the counter's decrement input
reject_pulse  output  1  one-cycle pulse when a completed passage is not counted (full or empty)
door_lock  output  1  combinational: people_count >= MAX_PEOPLE
passage_busy  output  1  FSM is not in IDLE
fault  output  1  FSM is in FAULT

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - All sync flops, filtered sensors, the timeout counter and every registered output go to 0.
  - FSM goes to IDLE.
  - Reset mid-passage discards the passage; no pulse is emitted.
- Input conditioning, per sensor:
  - Two-flop synchroniser.
  - Debouncer: the filtered value (fo = outer, fi = inner) takes the synchronised value only after it has differed from the current filtered value for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch shorter than that restarts the debounce count.
  - Latency from a raw edge to a filtered edge is 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, E_OUT, E_BOTH, E_IN, X_IN, X_BOTH, X_OUT, FAULT. The FSM evaluates {fo,fi} every cycle.
- IDLE:
  - 10 -> E_OUT
  - 01 -> X_IN
  - 11 -> FAULT (ambiguous)
  - 00 -> stay
- Entry path:
  - E_OUT: 11 -> E_BOTH; 00 -> IDLE (abort, no pulse); 01 -> FAULT.
  - E_BOTH: 01 -> E_IN; 10 -> E_OUT (backed out); 00 -> FAULT.
  - E_IN: 00 -> IDLE with entry complete; 11 -> E_BOTH; 10 -> FAULT.
- Exit path is the mirror image:
  - X_IN: 11 -> X_BOTH; 00 -> IDLE (abort, no pulse); 10 -> FAULT.
  - X_BOTH: 10 -> X_OUT; 01 -> X_IN (backed out); 00 -> FAULT.
  - X_OUT: 00 -> IDLE with exit complete; 11 -> X_BOTH; 01 -> FAULT.
- Completion outputs are registered and asserted in the same cycle the FSM register first holds IDLE. Each pulse lasts exactly one cycle.
  - Entry complete and people_count < MAX_PEOPLE: inc_pulse = 1.
  - Entry complete and people_count >= MAX_PEOPLE: reject_pulse = 1, no inc.
  - Exit complete and people_count != 0: dec_pulse = 1.
  - Exit complete and people_count == 0: reject_pulse = 1, no dec.
  - people_count is sampled in the cycle the completion transition is decided.
  - inc_pulse and dec_pulse are never high together; at most one of the three pulses is high in any cycle.
- Timeout:
  - A counter clears on every state change and in IDLE/FAULT, and increments otherwise.
  - If it reaches TIMEOUT_CYCLES-1 while the state is unchanged, the next state is FAULT; this overrides a simultaneous normal transition.
  - Saturates, no wrap.
- FAULT:
  - fault = 1 and passage_busy = 1; no pulses are issued.
  - Exits to IDLE after the cycle in which {fo,fi} = 00 is observed. The exit generates no pulse.
- door_lock is purely combinational from people_count and is independent of the FSM.
- Back-to-back passages: a new passage may start on the cycle after return to IDLE. No extra guard cycles are required.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, MAX_PEOPLE=10):
1. people_count=3; drive out=1, then both=1, then out=0, then in=0, each level held 10 cycles -> exactly one inc_pulse, 1 cycle wide, about 6 cycles after the last raw edge; no dec/reject; passage_busy low afterwards.
2. people_count=3; reverse sequence in -> both -> out -> none -> exactly one dec_pulse. Then out=1, out=0 (abort) -> no pulse and FSM back in IDLE.
3. people_count=10; full entry sequence -> door_lock=1, reject_pulse one cycle, inc_pulse never asserted. Repeat with people_count=0 and a full exit -> reject_pulse, no dec_pulse.
4. With sensors idle, 3-cycle glitches on sensor_out every 5 cycles for 100 cycles -> filtered state never changes; FSM stays IDLE; no outputs.
5. out=1 then both=1 held 80 cycles -> fault rises 64 cycles after entering E_BOTH. Release both -> fault clears after the debounce delay with no pulse. Then a normal entry -> inc_pulse.
6. Assert reset while in E_IN -> all outputs 0 immediately and IDLE. Release reset with sensor_in still 1 -> FSM goes to X_IN; no inc_pulse is ever produced for the interrupted entry.
